// File: rtl/fetch_stage.sv
// Fetch stage: PC plus synchronous-read IMEM feeding a small queue to decode. First valid 2 edges after issue, 1 instr/cycle.
// Stall holds the queue head; issue is throttled so queued words plus the in-flight read never exceed QDEPTH.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instruction,
  output logic [31:0]                   pc_out,
  output logic                          valid
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   r_mem     [IMEM_DEPTH];
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];
  logic [QW-1:0] r_rd_ptr;
  logic [QW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rd_pc;
  logic [31:0]   r_rd_data;
  logic          r_inflight;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_target;

  function automatic logic [QW-1:0] f_ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(QDEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & ~stall;
  // A redirect kills the word returning from the read issued on the previous edge.
  assign w_push   = r_inflight & ~redirect_valid;
  assign w_occ    = {1'b0, r_count} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, r_inflight};
  assign w_issue  = ~redirect_valid & (w_occ < (CW+1)'(QDEPTH));
  assign w_rd_idx = r_fetch_pc[AW+1:2];
  assign w_target = redirect_pc & 32'hFFFF_FFFC;

  // Nonblocking read of r_mem returns the pre-write word on a same-index collision.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_mem[imem_waddr] <= imem_wdata;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[w_rd_idx];
      r_rd_pc   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= r_rd_data;
      r_q_pc[r_wr_ptr]    <= r_rd_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign valid       = w_valid;
  assign instruction = w_valid ? r_q_instr[r_rd_ptr] : '0;
  assign pc_out      = w_valid ? r_q_pc[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, back-to-back redirects, then random traffic against a queue model.
module tb_fetch_stage;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .IMEM_DEPTH(256),
    .RESET_PC  (RESET_PC),
    .QDEPTH    (QDEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .valid         (valid)
  );

  // Reference: list of words handed to decode, plus at most one outstanding read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic [31:0] mmem [256];
  ent_t        mq[$];
  bit          m_pend = 1'b0;
  ent_t        m_pend_e;
  logic [31:0] m_fpc = RESET_PC;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cycle, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                            input bit we, input logic [7:0] wa, input logic [31:0] wd);
    int occ;
    bit pop;
    if (r) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc  = RESET_PC;
    end else if (rd) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc  = rp & ~32'h3;
    end else begin
      pop = (mq.size() > 0) && !s;
      occ = mq.size() - int'(pop) + int'(m_pend);
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pend_e);
      m_pend = 1'b0;
      if (occ < QDEPTH) begin
        m_pend_e.pc  = m_fpc;
        m_pend_e.ins = mmem[m_fpc[9:2]];
        m_pend       = 1'b1;
        m_fpc        = m_fpc + 32'd4;
      end
    end
    if (we) mmem[wa] = wd;
    if (mq.size() > QDEPTH) chk("model_depth", 32'(mq.size()), QDEPTH);
  endtask

  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                     input bit we, input logic [7:0] wa, input logic [31:0] wd);
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ei;
    rst = r; stall = s; redirect_valid = rd; redirect_pc = rp;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    model_edge(r, s, rd, rp, we, wa, wd);
    @(posedge clk);
    #1;
    cycle++;
    ev  = (mq.size() > 0);
    epc = ev ? mq[0].pc : 32'h0;
    ei  = ev ? mq[0].ins : 32'h0;
    chk("model_valid", 32'(valid), 32'(ev));
    chk("model_pc", pc_out, epc);
    chk("model_instr", instruction, ei);
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          we;
    logic [7:0]  wa;
    logic [31:0] wd;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ei;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                              input bit ev, input logic [31:0] epc, input logic [31:0] ei);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.rpc = rp;
    t.we = 1'b0; t.wa = 8'h0; t.wd = 32'h0;
    t.ev = ev; t.epc = epc; t.ei = ei;
    return t;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h1111_1111;
      1:       return 32'h2222_2222;
      2:       return 32'h3333_3333;
      3:       return 32'h4444_4444;
      16:      return 32'hDEAD_BEEF;
      default: return 32'hA000_0000 | 32'(i);
    endcase
  endfunction

  initial begin
    vec_t        vecs[$];
    vec_t        t;
    bit          r, s, rd, we;
    logic [31:0] rp, wd;
    logic [7:0]  wa;

    // Stream, stall hold, redirect, redirect under stall, wrap, mid-stream reset with write collision.
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h1111_1111));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h4,   32'h2222_2222));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4,   32'h2222_2222));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4,   32'h2222_2222));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4,   32'h2222_2222));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8,   32'h3333_3333));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hC,   32'h4444_4444));
    vecs.push_back(mk(0, 0, 1, 32'h43, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h40,  32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h44,  32'hA000_0011));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h44,  32'hA000_0011));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h44,  32'hA000_0011));
    vecs.push_back(mk(0, 1, 1, 32'h8, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8,   32'h3333_3333));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8,   32'h3333_3333));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hC,   32'h4444_4444));
    vecs.push_back(mk(0, 0, 1, 32'h3FC, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h3FC, 32'hA000_00FF));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h400, 32'h1111_1111));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h404, 32'h2222_2222));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h408, 32'h3333_3333));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h0));
    t = mk(0, 0, 0, 0, 0, 32'h0, 32'h0);
    t.we = 1'b1; t.wa = 8'h0; t.wd = 32'h5555_5555;
    vecs.push_back(t);
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h1111_1111));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h4,   32'h2222_2222));
    vecs.push_back(mk(0, 0, 1, 32'h0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h5555_5555));

    // Program load under reset; outputs must stay idle throughout.
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 0, 32'h0, 1, 8'(i), init_word(i));
    end

    foreach (vecs[k]) begin
      cyc(vecs[k].rst, vecs[k].stall, vecs[k].redir, vecs[k].rpc, vecs[k].we, vecs[k].wa, vecs[k].wd);
      chk($sformatf("tbl%0d_valid", k), 32'(valid), 32'(vecs[k].ev));
      chk($sformatf("tbl%0d_pc", k), pc_out, vecs[k].epc);
      chk($sformatf("tbl%0d_instr", k), instruction, vecs[k].ei);
    end

    // Back-to-back redirects: only the later target is fetched.
    cyc(0, 0, 1, 32'h100, 0, 8'h0, 32'h0);
    chk("b2b_valid0", 32'(valid), 32'h0);
    cyc(0, 0, 1, 32'h202, 0, 8'h0, 32'h0);
    chk("b2b_valid1", 32'(valid), 32'h0);
    cyc(0, 0, 0, 32'h0, 0, 8'h0, 32'h0);
    chk("b2b_valid2", 32'(valid), 32'h0);
    cyc(0, 0, 0, 32'h0, 0, 8'h0, 32'h0);
    chk("b2b_pc", pc_out, 32'h200);
    chk("b2b_instr", instruction, 32'hA000_0080);
    cyc(0, 0, 0, 32'h0, 0, 8'h0, 32'h0);
    chk("b2b_pc_next", pc_out, 32'h204);

    // Random traffic: stalls, redirects (incl. near 2^32 wrap), resets, writes biased to the fetch index.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) < 2);
      s  = ($urandom_range(99) < 40);
      rd = ($urandom_range(99) < 6);
      case ($urandom_range(2))
        0:       rp = $urandom;
        1:       rp = 32'($urandom_range(1023));
        default: rp = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      endcase
      we = ($urandom_range(99) < 15);
      wa = $urandom_range(1) ? m_fpc[9:2] : 8'($urandom_range(255));
      wd = $urandom;
      cyc(r, s, rd, rp, we, wa, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
